// File: rtl/por_seq_pkg.sv
// Shared types and constants for the power-on / pushbutton reset sequencer.
// Imported by the top level and its testbench.
package por_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_HOLD     = 3'd2,
    S_CAL_WAIT = 3'd3,
    S_RUN      = 3'd4,
    S_FAULT    = 3'd5
  } seq_state_t;

  // The FAULT heartbeat blinks this many times faster than the RUN heartbeat.
  localparam int FAULT_BLINK_DIV = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return max_int(1, $clog2(max_int(n, 2)));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs.
// Both stages reset synchronously to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments keep this a two-stage shift; blocking
  // assignments here would collapse both stages into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on / pushbutton reset sequencer: debounce, hold, release the MCU,
// wait for EMIF calibration, then release peripheral reset.
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1000,
  parameter int HOLD_CYCLES        = 10000000,
  parameter int CAL_TIMEOUT_CYCLES = 200000000,
  parameter int BLINK_CYCLES       = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       cal_success,
  input  logic       cal_fail,
  output logic       sys_reset,
  output logic       periph_reset,
  output logic [2:0] seq_state,
  output logic       cal_error,
  output logic       heartbeat
);

  localparam int SEQ_MAX = max_int(DEBOUNCE_CYCLES, max_int(HOLD_CYCLES, CAL_TIMEOUT_CYCLES));
  localparam int CNT_W   = cnt_width(SEQ_MAX);
  localparam int HB_W    = cnt_width(BLINK_CYCLES);
  localparam int FAULT_BLINK_CYCLES = max_int(1, BLINK_CYCLES / FAULT_BLINK_DIV);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_LAST   = CNT_W'(CAL_TIMEOUT_CYCLES - 1);
  localparam logic [HB_W-1:0]  RUN_LAST   = HB_W'(BLINK_CYCLES - 1);
  localparam logic [HB_W-1:0]  FAULT_LAST = HB_W'(FAULT_BLINK_CYCLES - 1);

  logic             btn_s, cs_s, cf_s;
  seq_state_t       state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [HB_W-1:0]  hb_cnt;
  logic [HB_W-1:0]  hb_last;

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({btn_n, cal_success, cal_fail}),
    .q     ({btn_s, cs_s, cf_s})
  );

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    next_state = state;
    cnt_next   = '0;
    case (state)
      S_RESET: next_state = S_DEBOUNCE;

      S_DEBOUNCE: begin
        if (btn_s) begin
          if (cnt == DEB_LAST) next_state = S_HOLD;
          else                 cnt_next   = cnt + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (!btn_s)                next_state = S_DEBOUNCE;
        else if (cnt == HOLD_LAST) next_state = S_CAL_WAIT;
        else                       cnt_next   = cnt + CNT_W'(1);
      end

      // Button beats everything; a fail beats a simultaneous success.
      S_CAL_WAIT: begin
        if (!btn_s)               next_state = S_DEBOUNCE;
        else if (cf_s)            next_state = S_FAULT;
        else if (cs_s)            next_state = S_RUN;
        else if (cnt == CAL_LAST) next_state = S_FAULT;
        else                      cnt_next   = cnt + CNT_W'(1);
      end

      S_RUN: begin
        if (!btn_s)             next_state = S_DEBOUNCE;
        else if (!cs_s || cf_s) next_state = S_FAULT;
      end

      S_FAULT: begin
        if (!btn_s) next_state = S_DEBOUNCE;
      end

      default: next_state = S_RESET;
    endcase
  end

  assign hb_last = (state == S_FAULT) ? FAULT_LAST : RUN_LAST;

  // Outputs are derived from next_state so they move on the same edge as state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RESET;
      cnt          <= '0;
      hb_cnt       <= '0;
      sys_reset    <= 1'b1;
      periph_reset <= 1'b1;
      cal_error    <= 1'b0;
      heartbeat    <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= cnt_next;
      // The MCU stays out of reset in FAULT so it can report the error.
      sys_reset    <= (next_state == S_RESET) || (next_state == S_DEBOUNCE) ||
                      (next_state == S_HOLD);
      periph_reset <= (next_state != S_RUN);

      if (state == S_FAULT && next_state != S_FAULT) cal_error <= 1'b0;
      else if (next_state == S_FAULT)                 cal_error <= 1'b1;

      if (next_state != state ||
          !(next_state == S_RUN || next_state == S_FAULT)) begin
        hb_cnt    <= '0;
        heartbeat <= 1'b0;
      end else if (hb_cnt == hb_last) begin
        hb_cnt    <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        hb_cnt    <= hb_cnt + HB_W'(1);
      end
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench for por_reset_sequencer with short timing parameters;
// expected values are hand-derived edge counts from reset release.
module tb_por_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_n;
  logic       cal_success;
  logic       cal_fail;
  logic       sys_reset;
  logic       periph_reset;
  logic [2:0] seq_state;
  logic       cal_error;
  logic       heartbeat;

  int checks   = 0;
  int failures = 0;

  por_reset_sequencer #(
    .DEBOUNCE_CYCLES    (4),
    .HOLD_CYCLES        (10),
    .CAL_TIMEOUT_CYCLES (50),
    .BLINK_CYCLES       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_n        (btn_n),
    .cal_success  (cal_success),
    .cal_fail     (cal_fail),
    .sys_reset    (sys_reset),
    .periph_reset (periph_reset),
    .seq_state    (seq_state),
    .cal_error    (cal_error),
    .heartbeat    (heartbeat)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    btn_n       = 1'b1;
    cal_success = 1'b0;
    cal_fail    = 1'b0;

    // Reset state
    tick(3);
    check("rst_state",  32'(seq_state), 0);
    check("rst_sys",    32'(sys_reset), 1);
    check("rst_periph", 32'(periph_reset), 1);
    check("rst_calerr", 32'(cal_error), 0);
    check("rst_hb",     32'(heartbeat), 0);

    // Clean bring-up: HOLD at edge 6, CAL_WAIT (sys_reset low) at edge 16
    reset = 1'b0;
    tick(6);
    check("up_hold_e6",  32'(seq_state), 2);
    tick(9);
    check("up_state_e15", 32'(seq_state), 2);
    check("up_sys_e15",   32'(sys_reset), 1);
    tick(1);
    check("up_state_e16", 32'(seq_state), 3);
    check("up_sys_e16",   32'(sys_reset), 0);
    check("up_periph_e16", 32'(periph_reset), 1);

    // Calibration success: RUN three edges later
    cal_success = 1'b1;
    tick(2);
    check("cs_state_e2",  32'(seq_state), 3);
    check("cs_periph_e2", 32'(periph_reset), 1);
    tick(1);
    check("cs_state_e3",  32'(seq_state), 4);
    check("cs_periph_e3", 32'(periph_reset), 0);
    check("run_hb_0",     32'(heartbeat), 0);
    tick(7);
    check("run_hb_7",  32'(heartbeat), 0);
    tick(1);
    check("run_hb_8",  32'(heartbeat), 1);
    tick(7);
    check("run_hb_15", 32'(heartbeat), 1);
    tick(1);
    check("run_hb_16", 32'(heartbeat), 0);

    // RUN loss: FAULT three edges after cal_success drops
    cal_success = 1'b0;
    tick(2);
    check("loss_state_e2", 32'(seq_state), 4);
    tick(1);
    check("loss_state_e3",  32'(seq_state), 5);
    check("loss_periph",    32'(periph_reset), 1);
    check("loss_sys",       32'(sys_reset), 0);
    check("loss_calerr",    32'(cal_error), 1);
    check("loss_hb_0",      32'(heartbeat), 0);
    tick(1);
    check("loss_hb_1", 32'(heartbeat), 1);
    tick(1);
    check("loss_hb_2", 32'(heartbeat), 0);

    // Button out of FAULT, held low for 5 cycles
    btn_n = 1'b0;
    tick(2);
    check("btn1_state_e2",  32'(seq_state), 5);
    check("btn1_calerr_e2", 32'(cal_error), 1);
    tick(1);
    check("btn1_state_e3",  32'(seq_state), 1);
    check("btn1_calerr_e3", 32'(cal_error), 0);
    check("btn1_sys_e3",    32'(sys_reset), 1);
    tick(2);
    btn_n = 1'b1;
    tick(5);
    check("btn1_deb_e10",  32'(seq_state), 1);
    tick(1);
    check("btn1_hold_e11", 32'(seq_state), 2);

    // Bounce: one-cycle low at HOLD count 7 returns to DEBOUNCE
    tick(7);
    btn_n = 1'b0;
    tick(1);
    btn_n = 1'b1;
    tick(1);
    check("bnc_state_h9",  32'(seq_state), 2);
    tick(1);
    check("bnc_state_h10", 32'(seq_state), 1);
    check("bnc_sys_h10",   32'(sys_reset), 1);
    tick(13);
    check("bnc_state_h23", 32'(seq_state), 2);
    check("bnc_sys_h23",   32'(sys_reset), 1);
    tick(1);
    check("bnc_state_h24", 32'(seq_state), 3);
    check("bnc_sys_h24",   32'(sys_reset), 0);

    // Calibration timeout after 50 cycles in CAL_WAIT
    tick(49);
    check("to_state_49",  32'(seq_state), 3);
    check("to_calerr_49", 32'(cal_error), 0);
    tick(1);
    check("to_state_50",  32'(seq_state), 5);
    check("to_calerr_50", 32'(cal_error), 1);
    check("to_sys_50",    32'(sys_reset), 0);
    check("to_periph_50", 32'(periph_reset), 1);
    check("to_hb_50",     32'(heartbeat), 0);
    tick(1);
    check("to_hb_51", 32'(heartbeat), 1);
    tick(1);
    check("to_hb_52", 32'(heartbeat), 0);

    // Button out again and re-enter CAL_WAIT
    btn_n = 1'b0;
    tick(3);
    check("btn2_state",  32'(seq_state), 1);
    check("btn2_calerr", 32'(cal_error), 0);
    tick(2);
    btn_n = 1'b1;
    tick(6);
    check("btn2_hold", 32'(seq_state), 2);
    tick(10);
    check("btn2_cal",  32'(seq_state), 3);

    // Simultaneous success and fail: fail wins
    cal_success = 1'b1;
    cal_fail    = 1'b1;
    tick(2);
    check("sim_state_e2", 32'(seq_state), 3);
    tick(1);
    check("sim_state_e3",  32'(seq_state), 5);
    check("sim_calerr_e3", 32'(cal_error), 1);
    check("sim_periph_e3", 32'(periph_reset), 1);
    cal_success = 1'b0;
    cal_fail    = 1'b0;

    // Button clears the error and restarts debounce
    btn_n = 1'b0;
    tick(3);
    check("btn3_state",  32'(seq_state), 1);
    check("btn3_calerr", 32'(cal_error), 0);
    check("btn3_sys",    32'(sys_reset), 1);
    tick(2);
    btn_n = 1'b1;
    tick(6);
    check("btn3_hold", 32'(seq_state), 2);

    // Reset at HOLD count 5
    tick(5);
    check("mid_state_pre", 32'(seq_state), 2);
    reset = 1'b1;
    tick(1);
    check("mid_state",  32'(seq_state), 0);
    check("mid_sys",    32'(sys_reset), 1);
    check("mid_calerr", 32'(cal_error), 0);
    check("mid_hb",     32'(heartbeat), 0);

    // Second bring-up from reset uses the same release timing
    reset = 1'b0;
    tick(1);
    check("re_state_e1",  32'(seq_state), 1);
    tick(14);
    check("re_sys_e15",   32'(sys_reset), 1);
    tick(1);
    check("re_state_e16", 32'(seq_state), 3);
    check("re_sys_e16",   32'(sys_reset), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
